// File: rtl/clk_ratio_meter.sv
// Measures the period and high time of a slow/divided clock in clk cycles, with lock and timeout.
// Define CLKMON_SYNC_EN for a two-flop input synchronizer; otherwise sig_in must come from clk.
module clk_ratio_meter #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cyc,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
  output logic             active
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);
  localparam logic [3:0]       MATCH_MAX = 4'(LOCK_CNT - 1);

  typedef enum logic [1:0] {IDLE, ARMED, MEAS} state_t;

  logic s;
  logic s_d_reg;
  logic rise;
  logic fall;

`ifdef CLKMON_SYNC_EN
  logic [1:0] sync_reg;
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], sig_in};
  end
  assign s = sync_reg[1];
`else
  logic sync_reg;
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 1'b0;
    else     sync_reg <= sig_in;
  end
  assign s = sync_reg;
`endif

  assign rise = s & ~s_d_reg;
  assign fall = ~s & s_d_reg;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;

  // Both counters restart at 1 so the count on the next rise equals the edge distance.
  always_comb begin
    cnt_next  = cnt_reg;
    hcnt_next = hcnt_reg;
    if (rise) begin
      cnt_next  = CNT_W'(1);
      hcnt_next = CNT_W'(1);
    end else begin
      if (cnt_reg != CNT_MAX)
        cnt_next = cnt_reg + CNT_W'(1);
      if (s && hcnt_reg != CNT_MAX)
        hcnt_next = hcnt_reg + CNT_W'(1);
    end
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic [3:0]       match_reg, match_next;
  logic             mv_reg, mv_next;
  logic             locked_reg, locked_next;
  logic             to_reg, to_next;

  always_comb begin
    state_next  = state_reg;
    period_next = period_reg;
    high_next   = high_reg;
    match_next  = match_reg;
    mv_next     = 1'b0;
    locked_next = locked_reg;
    to_next     = 1'b0;

    if (state_reg != IDLE && fall)
      high_next = hcnt_reg;

    case (state_reg)
      IDLE: begin
        if (rise) state_next = ARMED;
      end
      ARMED, MEAS: begin
        if (rise) begin
          state_next  = MEAS;
          period_next = cnt_reg;
          mv_next     = 1'b1;
          if (state_reg == MEAS && cnt_reg == period_reg)
            match_next = (match_reg == MATCH_MAX) ? match_reg : match_reg + 4'd1;
          else
            match_next = 4'd0;
          locked_next = (match_next == MATCH_MAX);
        end else if (cnt_reg == TO_VAL) begin
          // A rise in the same cycle takes the branch above and is a normal measurement.
          state_next  = IDLE;
          to_next     = 1'b1;
          match_next  = 4'd0;
          locked_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_d_reg    <= 1'b0;
      cnt_reg    <= '0;
      hcnt_reg   <= '0;
      state_reg  <= IDLE;
      period_reg <= '0;
      high_reg   <= '0;
      match_reg  <= 4'd0;
      mv_reg     <= 1'b0;
      locked_reg <= 1'b0;
      to_reg     <= 1'b0;
    end else begin
      s_d_reg    <= s;
      cnt_reg    <= cnt_next;
      hcnt_reg   <= hcnt_next;
      state_reg  <= state_next;
      period_reg <= period_next;
      high_reg   <= high_next;
      match_reg  <= match_next;
      mv_reg     <= mv_next;
      locked_reg <= locked_next;
      to_reg     <= to_next;
    end
  end

  assign period     = period_reg;
  assign high_cyc   = high_reg;
  assign meas_valid = mv_reg;
  assign locked     = locked_reg;
  assign timeout    = to_reg;
  assign active     = (state_reg != IDLE);

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: tables of sig_in periods with expected measurements,
// plus hand-written timeout, reset and edge-alignment sequences.
module tb_clk_ratio_meter;

  localparam int CNT_W = 16;
  localparam int TOUT  = 50;
`ifdef CLKMON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cyc;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
  logic             active;

  clk_ratio_meter #(.CNT_W(CNT_W), .LOCK_CNT(4), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period(period), .high_cyc(high_cyc),
    .meas_valid(meas_valid), .locked(locked), .timeout(timeout), .active(active)
  );

  always #10 clk = ~clk;

  typedef struct { int h; int l; bit mv; int p; int hc; bit lk; } vec_t;
  typedef struct { int p; int hc; bit lk; int cyc; } rec_t;

  vec_t tbl[$];
  rec_t recs[$];
  int   cyc = 0;
  int   to_cnt = 0;
  int   to_cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid) begin
      recs.push_back('{int'(period), int'(high_cyc), locked, cyc});
      $display("meas_valid @%0d period=%0d high_cyc=%0d locked=%0b", cyc, period, high_cyc, locked);
    end
    if (timeout) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
      $display("timeout @%0d", cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act == exp) passed = passed + 1;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input int h, input int l);
    sig_in = 1'b1;
    repeat (h) step();
    sig_in = 1'b0;
    repeat (l) step();
  endtask

  task automatic add(input int h, input int l, input bit mv, input int p, input int hc, input bit lk);
    tbl.push_back('{h, l, mv, p, hc, lk});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high_cyc"}, int'(high_cyc), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_active"}, int'(active), 0);
  endtask

  task automatic run_table(input string tag);
    int base;
    int n;
    int k;
    base = recs.size();
    n = 0;
    foreach (tbl[i]) begin
      drive_row(tbl[i].h, tbl[i].l);
      if (tbl[i].mv) n++;
    end
    repeat (4) step();
    chk({tag, "_mv_count"}, recs.size() - base, n);
    k = base;
    foreach (tbl[i]) begin
      if (tbl[i].mv) begin
        if (k < recs.size()) begin
          chk($sformatf("%s_row%0d_period", tag, i), recs[k].p, tbl[i].p);
          chk($sformatf("%s_row%0d_high", tag, i), recs[k].hc, tbl[i].hc);
          chk($sformatf("%s_row%0d_locked", tag, i), int'(recs[k].lk), int'(tbl[i].lk));
        end
        k++;
      end
    end
    tbl.delete();
  endtask

  initial begin
    int to0;
    int base;
    int t1;
    sig_in = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_reset_vals("init");

    // Divide-by-2: each row measures the period that ended at its own rising edge.
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 2, 1, 0);
    add(1, 1, 1, 2, 1, 0);
    add(1, 1, 1, 2, 1, 0);
    add(1, 1, 1, 2, 1, 1);
    add(1, 1, 1, 2, 1, 1);
    add(1, 1, 1, 2, 1, 1);
    add(1, 1, 1, 2, 1, 1);
    run_table("div2");

    // Divide-by-10 then divide-by-8.
    do_reset();
    add(5, 5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(5, 5, 1, 10, 5, 0);
    for (int i = 0; i < 2; i++) add(5, 5, 1, 10, 5, 1);
    add(4, 4, 1, 10, 5, 1);
    for (int i = 0; i < 3; i++) add(4, 4, 1, 8, 4, 0);
    for (int i = 0; i < 2; i++) add(4, 4, 1, 8, 4, 1);
    run_table("div10_8");

    // Input stops after lock.
    to0 = to_cnt;
    for (int i = 0; i < 200 && to_cnt == to0; i++) step();
    chk("timeout_seen", to_cnt - to0, 1);
    chk("timeout_delay", to_cyc - recs[recs.size()-1].cyc, TOUT);
    repeat (3) step();
    chk("timeout_single_pulse", to_cnt - to0, 1);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_active", int'(active), 0);
    chk("timeout_period_kept", int'(period), 8);
    chk("timeout_high_kept", int'(high_cyc), 4);
    base = recs.size();
    drive_row(3, 3);
    drive_row(3, 3);
    repeat (4) step();
    chk("restart_mv_count", recs.size() - base, 1);
    chk("restart_period", int'(period), 6);
    chk("restart_active", int'(active), 1);

    // Reset in the low half of a period while measuring.
    drive_row(3, 3);
    drive_row(3, 3);
    sig_in = 1'b1;
    repeat (2) step();
    sig_in = 1'b0;
    step();
    do_reset();
    chk_reset_vals("midrst");
    to0 = to_cnt;
    repeat (60) step();
    chk("idle_no_timeout", to_cnt - to0, 0);
    base = recs.size();
    drive_row(3, 3);
    chk("one_rise_no_mv", recs.size() - base, 0);
    sig_in = 1'b1;
    t1 = cyc;
    repeat (3) step();
    sig_in = 1'b0;
    repeat (3) step();
    chk("two_rise_mv_count", recs.size() - base, 1);
    if (recs.size() > base) begin
      chk("mv_latency", recs[base].cyc - t1, LAT);
      chk("post_rst_period", recs[base].p, 6);
      chk("post_rst_high", recs[base].hc, 3);
    end

    // Rise lands on the cycle where cnt reaches TIMEOUT: measurement wins.
    do_reset();
    to0 = to_cnt;
    add(25, 25, 0, 0, 0, 0);
    add(25, 25, 1, TOUT, 25, 0);
    add(25, 25, 1, TOUT, 25, 0);
    add(2, 2, 1, TOUT, 25, 0);
    run_table("align");
    chk("align_no_timeout", to_cnt - to0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

- Receive-side companion to the team's clock-divider blocks.
- Samples a divided or slow clock (`sig_in`) in the fast `clk` domain and measures its period and high time in `clk` cycles.
- Reports when the ratio is stable (locked) and when the slow clock has stopped (timeout).
- Used in lab benches and on-board to check divider outputs against the expected ratio.

## Interface
Parameters:
- `CNT_W`, 16 — width of the period and high-time counters and outputs.
- `LOCK_CNT`, 4 — number of consecutive identical periods required to assert `locked`. Range 2..15.
- `TIMEOUT`, 1000 — cycles without a rising edge before the input is declared dead. Must satisfy 2 ≤ `TIMEOUT` ≤ 2^`CNT_W`−1.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1 — measurement clock; all logic is on its rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `sig_in` input 1 — slow or divided clock to be measured; may be asynchronous to `clk`.
- `period` output `CNT_W` — last measured rising-to-rising interval, in `clk` cycles.
- `high_cyc` output `CNT_W` — last measured rising-to-falling interval, in `clk` cycles.
- `meas_valid` output 1 — one-cycle pulse when `period` updates.
- `locked` output 1 — level; `LOCK_CNT` consecutive equal periods have been seen.
- `timeout` output 1 — one-cycle pulse when `TIMEOUT` is reached.
- `active` output 1 — level; high in states ARMED and MEAS.

## Operation
- Input path:
  - Synchronizer (see Configuration) produces `s`.
  - `s_d` is `s` delayed one cycle.
  - `rise = s & ~s_d`; `fall = ~s & s_d`.
- Counters:
  - `cnt` loads 1 on `rise`, otherwise increments.
  - `hcnt` loads 1 on `rise`, increments while `s` is high.
  - Both saturate at 2^`CNT_W`−1; no wrap.
- State machine:
  - **IDLE**: no edge reference. `rise` → ARMED. No measurement is taken.
  - **ARMED**: one edge seen. `rise` → MEAS; `period <= cnt`; pulse `meas_valid`; `match` cleared.
  - **MEAS**: on each `rise`, `period <= cnt` and pulse `meas_valid`.
    - If `cnt == period`: `match` increments, saturating at `LOCK_CNT`−1.
    - Otherwise: `match` clears to 0.
    - `locked` = (`match` == `LOCK_CNT`−1) registered, so it rises on the same edge as the matching `meas_valid`.
    - A mismatch deasserts `locked` on the same edge as its `meas_valid`.
- High time: on `fall` in ARMED or MEAS, `high_cyc <= hcnt`. A `fall` in IDLE is ignored.
- Timeout: in ARMED or MEAS, if `cnt == TIMEOUT` and no `rise` occurs in that cycle:
  - Go to IDLE; pulse `timeout`; clear `locked` and `match`.
  - `period` and `high_cyc` hold their last values.
  - `timeout` never pulses in IDLE.
- Simultaneous events: when `rise` and `cnt == TIMEOUT` occur in the same cycle, `rise` wins and counts as a normal measurement.

## Timing
- Reset values: `period`=0, `high_cyc`=0, `meas_valid`=0, `locked`=0, `timeout`=0, `active`=0. State = IDLE; `cnt`, `hcnt` and `match` = 0; synchronizer flops = 0.
- `rst` mid-operation: all of the above apply on the next edge; any measurement in progress is discarded.
- `rst` has priority over every event.
- Latency from the `clk` edge that first samples `sig_in` high (edge k):
  - `rise` is active during the cycle after edge k+1.
  - `meas_valid`, `period` and `locked` update at edge k+2.
  - Without the macro, these are one cycle earlier.
- The same latency applies to `fall` → `high_cyc`.
- `period` is exactly the number of `clk` edges between two sampled rising edges. Example: a 2-cycle-period `sig_in` yields `period`=2.
- Minimum measurable period is 2. A `sig_in` faster than `clk`/2 is aliased; no detection is required.

## Configuration
- Macro `CLKMON_SYNC_EN`.
- Defined: two-flop synchronizer on `sig_in`, latency as stated above.
- Undefined: single register stage, one cycle less latency. Only valid when `sig_in` is generated from `clk`.
- Measured values are identical in both builds for a synchronous input.

## Test plan
- `clk` 20 ns; `sig_in` = `clk`/2 from the divider, i.e. toggling every `clk` rising edge.
  - Required: `period`=2 and `high_cyc`=1 on every `meas_valid`.
  - Required: `locked`=1 at the 4th `meas_valid` after ARMED.
- Divide-by-10 input, 50% duty → `period`=10, `high_cyc`=5; `locked` holds.
  - Then switch to divide-by-8 → the first mismatch drops `locked` on its `meas_valid`.
  - `locked` reasserts after 4 consecutive 8s.
- Hold `sig_in` low after locking, `TIMEOUT`=50:
  - `timeout` pulses exactly 50 cycles after the last `rise`.
  - `locked`=0, `active`=0; `period` is retained.
  - The next two rising edges produce one new `meas_valid`.
- Assert `rst` for one cycle in the middle of a period:
  - All outputs read reset values on the next edge.
  - The first `meas_valid` occurs only after two further rising edges.
- Edge alignment: place a `sig_in` rising edge so that `rise` coincides with `cnt == TIMEOUT`.
  - Required: `meas_valid` with `period`=`TIMEOUT`; no `timeout` pulse.
- Run the build without `CLKMON_SYNC_EN` on the divide-by-2 stimulus:
  - `meas_valid` occurs one cycle earlier than in the synchronized build.
  - `period` and `high_cyc` values are identical.
